apb4_reg_bridge: RTL
====================

Name: apb4_reg_bridge

Overview:
- APB4 completer that turns APB4 transfers into single-request transactions on the register bus.
- Sits directly upstream of the CSR/RegMap and drives the BUS modport of Bus2Reg_intf.
- Adds address-alignment and privilege checks, strobe-to-bit-enable expansion, and a response timeout so a silent register map cannot hang the APB.

Parameters:
- DATA_WIDTH, 32: APB data width and register-bus data width; must be a multiple of 8.
- ADDR_WIDTH, 11: byte address width; bus_addr = PADDR[ADDR_WIDTH-1:0].
- TIMEOUT_CYCLES, 16: maximum cycles spent waiting for bus_ready; 0 disables the timeout.
- PRIV_ONLY, 0: when 1, accesses with PPROT[0]=0 complete with an error and never reach the bus.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-low.
- psel  input  1  APB select.
- penable  input  1  APB enable.
- pwrite  input  1  APB write.
- paddr  input  ADDR_WIDTH  APB byte address.
- pwdata  input  DATA_WIDTH  APB write data.
- pstrb  input  DATA_WIDTH/8  APB write strobes.
- pprot  input  3  APB protection.
- pready  output  1  APB ready.
- prdata  output  DATA_WIDTH  APB read data.
- pslverr  output  1  APB error.
- bus_req  output  1  one-cycle request pulse.
- bus_req_is_wr  output  1  request is a write.
- bus_addr  output  ADDR_WIDTH  request address.
- bus_wr_data  output  DATA_WIDTH  write data.
- bus_wr_biten  output  DATA_WIDTH  write bit enables.
- bus_req_stall_wr  output  1  write outstanding.
- bus_req_stall_rd  output  1  read outstanding.
- bus_ready  input  1  RegMap completion.
- bus_err  input  1  RegMap error, qualified by bus_ready.
- bus_rd_data  input  DATA_WIDTH  RegMap read data, qualified by bus_ready.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, timeout counter 0, all outputs 0.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - On psel=1, penable=0 (setup phase), register pwrite, paddr, pwdata, strobes and pprot.
  - Check the access: misaligned (paddr[1:0]!=0) or privilege violation (PRIV_ONLY=1 and pprot[0]=0).
  - Failed check -> RESP with err=1 and no bus_req. Otherwise -> REQ.
- REQ:
  - bus_req=1 for exactly one cycle.
  - bus_addr, bus_wr_data, bus_wr_biten and bus_req_is_wr are held stable from REQ until RESP exits.
  - bus_wr_biten[8i+7:8i] = {8{pstrb[i]}} on writes; all zeros on reads.
  - If bus_ready=1 in this same cycle -> RESP; else -> WAIT.
- WAIT:
  - bus_req=0.
  - bus_req_stall_wr = is_wr; bus_req_stall_rd = !is_wr.
  - On bus_ready=1: capture bus_err, and capture bus_rd_data on reads (prdata stays 0 on writes) -> RESP.
- Timeout:
  - Counter is cleared on entering REQ and increments each cycle in REQ/WAIT without bus_ready.
  - When it reaches TIMEOUT_CYCLES (nonzero), go to RESP with err=1 and prdata=0.
  - bus_ready arriving in the same cycle as expiry wins: normal completion.
- RESP:
  - pready=1, pslverr=err, prdata=captured data, for exactly one cycle -> IDLE.
  - prdata and pslverr return to 0 in IDLE.
- pready is 0 in every state except RESP.
- Minimum transfer length is 3 cycles (setup, REQ with ready, RESP); each cycle of bus_ready delay adds one.
- bus_ready, bus_err and bus_rd_data are ignored in IDLE and RESP; a late ready after a timeout is dropped.
- psel dropping mid-transfer is an APB protocol violation. The bridge still finishes its FSM (REQ/WAIT/RESP) and returns to IDLE, and does not issue a second bus_req.
- Back-to-back transfers: a new setup phase is accepted in the cycle after RESP, giving no bubble beyond the APB setup cycle.
- Reset mid-transaction aborts immediately; no bus_req is issued afterwards.

Decomposition:
- Package apb4_reg_pkg holds:
  - the FSM state enum (IDLE, REQ, WAIT, RESP);
  - a strobe-expansion function parameterised by DATA_WIDTH;
  - the timeout counter width constant, $clog2(TIMEOUT_CYCLES+1).
- One natural sub-module: reg_bus_timeout, a loadable counter with clear, enable and expired outputs, disabled when TIMEOUT_CYCLES=0.

Test Plan:
- Write, no wait: write to addr 0x010, pwdata=0xDEADBEEF, pstrb=4'b0101, bus_ready in the REQ cycle -> one bus_req pulse with biten=0x00FF00FF; pready on cycle 3; pslverr=0.
- Read with wait: read from addr 0x020, bus_ready 4 cycles after bus_req with rd_data=0x12345678 -> stall_rd high for 4 cycles; prdata=0x12345678 with pready; stall_wr stays 0.
- Misaligned: write to paddr=0x013 -> no bus_req; pready with pslverr=1 on cycle 2.
- PRIV_ONLY=1: read with pprot=3'b000 -> error response, no bus_req; with pprot=3'b001 -> normal access.
- Timeout: TIMEOUT_CYCLES=16, bus_ready never asserts -> pready with pslverr=1 and prdata=0 exactly 16 cycles after bus_req; a bus_ready injected 2 cycles later -> no effect.
- Reset mid-transfer: rst low during WAIT -> all outputs 0 asynchronously; after release, next transfer completes normally.

Source files
------------

// File: rtl/apb4_reg_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// apb4_reg_pkg : shared states and helpers for the APB4 register bridge
// Rev 1.0
// ---------------------------------------------------------------------------
package apb4_reg_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_REQ  = 2'd1;
  localparam state_t ST_WAIT = 2'd2;
  localparam state_t ST_RESP = 2'd3;

  // Width holding 0..cycles; at least one bit so a disabled timeout still elaborates
  function automatic int unsigned tmo_cnt_width(input int unsigned cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

  function automatic logic [7:0] strb_to_biten(input logic strb, input logic is_wr);
    return (strb && is_wr) ? 8'hFF : 8'h00;
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb4_reg_bridge_timeout.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// reg_bus_timeout : cycle counter flagging a register-bus response that never came
// Rev 1.0
// ---------------------------------------------------------------------------
module reg_bus_timeout
  import apb4_reg_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = tmo_cnt_width(TIMEOUT_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  generate
    if (TIMEOUT_CYCLES != 0) begin : g_count
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
          cnt_d = '0;
        end else if (en_i) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      // Fires in the cycle whose increment would reach the limit
      assign expired_o = en_i && !clr_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    end else begin : g_disabled
      assign expired_o = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/apb4_reg_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// apb4_reg_bridge : APB4 completer issuing single requests on the register bus
// Rev 1.0
// ---------------------------------------------------------------------------
module apb4_reg_bridge
  import apb4_reg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 11,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter bit          PRIV_ONLY      = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [2:0]              pprot,
  output logic                    pready,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pslverr,
  output logic                    bus_req,
  output logic                    bus_req_is_wr,
  output logic [ADDR_WIDTH-1:0]   bus_addr,
  output logic [DATA_WIDTH-1:0]   bus_wr_data,
  output logic [DATA_WIDTH-1:0]   bus_wr_biten,
  output logic                    bus_req_stall_wr,
  output logic                    bus_req_stall_rd,
  input  logic                    bus_ready,
  input  logic                    bus_err,
  input  logic [DATA_WIDTH-1:0]   bus_rd_data
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;

  state_t                  state_q, state_d;
  logic                    is_wr_q, is_wr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [NBYTES-1:0]       strb_q, strb_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic setup;
  logic access_bad;
  logic busy;
  logic expired;
  logic prot_unused;

  assign setup       = psel && !penable;
  assign access_bad  = (paddr[1:0] != 2'b00) || (PRIV_ONLY && !pprot[0]);
  assign busy        = (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign prot_unused = ^pprot[2:1];

  always_comb begin
    state_d = state_q;
    is_wr_d = is_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (setup) begin
          is_wr_d = pwrite;
          addr_d  = paddr;
          wdata_d = pwdata;
          strb_d  = pstrb;
          err_d   = access_bad;
          rdata_d = '0;
          state_d = access_bad ? ST_RESP : ST_REQ;
        end
      end
      ST_REQ, ST_WAIT: begin
        // A response in the expiry cycle still counts as a normal completion
        if (bus_ready) begin
          err_d   = bus_err;
          rdata_d = is_wr_q ? '0 : bus_rd_data;
          state_d = ST_RESP;
        end else if (expired) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        err_d   = 1'b0;
        rdata_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  reg_bus_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (!busy),
    .en_i      (busy && !bus_ready),
    .expired_o (expired)
  );

  generate
    for (genvar i = 0; i < NBYTES; i++) begin : g_biten
      assign bus_wr_biten[8*i +: 8] = strb_to_biten(strb_q[i], is_wr_q);
    end
  endgenerate

  assign pready           = (state_q == ST_RESP);
  assign pslverr          = pready && err_q;
  assign prdata           = pready ? rdata_q : '0;
  assign bus_req          = (state_q == ST_REQ);
  assign bus_req_is_wr    = is_wr_q;
  assign bus_addr         = addr_q;
  assign bus_wr_data      = wdata_q;
  assign bus_req_stall_wr = (state_q == ST_WAIT) && is_wr_q;
  assign bus_req_stall_rd = (state_q == ST_WAIT) && !is_wr_q;

endmodule
`default_nettype wire
